// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL simulation model.
// Holds period width, lock FSM state encoding and counter helpers.
package pll_pkg;

   localparam int PERIOD_W = 32;
   localparam int CNT_W    = 8;

   // Encoding 2'd3 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/period_match.sv
// Combinational period comparator: match when |a - b| <= TOLERANCE.
// Difference is taken one bit wider than the operands, so it never wraps.
module period_match #(
   parameter int PERIOD_W  = 32,
   parameter int TOLERANCE = 1
) (
   input  logic [PERIOD_W-1:0] a,
   input  logic [PERIOD_W-1:0] b,
   output logic                match
);

   logic [PERIOD_W:0] a_ext;
   logic [PERIOD_W:0] b_ext;
   logic [PERIOD_W:0] diff;

   always_comb begin
      a_ext = {1'b0, a};
      b_ext = {1'b0, b};
      diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
      match = (diff <= (PERIOD_W+1)'(TOLERANCE));
   end

endmodule

// File: rtl/period_lock_detect.sv
// Lock detector on the measured input period: acquires, holds and
// drops lock with hysteresis, and reports the settled period.
module period_lock_detect
   import pll_pkg::*;
#(
   parameter int PERIOD_W      = pll_pkg::PERIOD_W,
   parameter int LOCK_CYCLES   = 8,
   parameter int UNLOCK_CYCLES = 2,
   parameter int TOLERANCE     = 1,
   parameter int MIN_PERIOD    = 1,
   parameter int MAX_PERIOD    = 1000
) (
   input  logic                clk,
   input  logic                RST,
   input  logic                PWRDWN,
   input  logic [PERIOD_W-1:0] period_length,
   output logic                LOCKED,
   output logic [PERIOD_W-1:0] stable_period,
   output logic                out_of_range,
   output logic [CNT_W-1:0]    match_count
);

   localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_CYCLES);
   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

   state_e              state;
   state_e              state_n;
   logic [PERIOD_W-1:0] prev;
   logic [PERIOD_W-1:0] prev_n;
   logic [CNT_W-1:0]    miss;
   logic [CNT_W-1:0]    miss_n;
   logic [CNT_W-1:0]    cnt_n;
   logic [CNT_W-1:0]    cnt_inc;
   logic [CNT_W-1:0]    miss_inc;
   logic                lock_n;
   logic [PERIOD_W-1:0] stab_n;
   logic                oor_n;

   logic                valid;
   logic                in_rng;
   logic [PERIOD_W-1:0] ref_p;
   logic                near;
   logic                match;

   // Reference is the last sample while acquiring, the held period once locked.
   always_comb begin
      valid  = (period_length != '0);
      in_rng = (period_length >= MIN_P) && (period_length <= MAX_P);
      ref_p  = (state == ST_LOCKED) ? stable_period : prev;
      match  = near && (ref_p != '0);
   end

   period_match #(
      .PERIOD_W  (PERIOD_W),
      .TOLERANCE (TOLERANCE)
   ) u_match (
      .a     (period_length),
      .b     (ref_p),
      .match (near)
   );

   always_comb begin
      cnt_inc  = sat_inc(match_count);
      miss_inc = sat_inc(miss);
   end

   always_comb begin
      state_n = state;
      prev_n  = period_length;
      miss_n  = miss;
      cnt_n   = match_count;
      lock_n  = LOCKED;
      stab_n  = stable_period;
      oor_n   = valid && !in_rng;

      unique case (state)
         ST_IDLE: begin
            if (valid && in_rng) begin
               state_n = ST_ACQUIRE;
               cnt_n   = '0;
            end
         end
         ST_ACQUIRE: begin
            if (!valid) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (!in_rng || !match) begin
               cnt_n = '0;
            end else begin
               cnt_n = cnt_inc;
               if (cnt_inc == LOCK_N) begin
                  state_n = ST_LOCKED;
                  lock_n  = 1'b1;
                  stab_n  = period_length;
                  miss_n  = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (!valid) begin
               state_n = ST_IDLE;
               lock_n  = 1'b0;
               stab_n  = '0;
               cnt_n   = '0;
               miss_n  = '0;
            end else if (!in_rng) begin
               state_n = ST_ACQUIRE;
               lock_n  = 1'b0;
               stab_n  = '0;
               cnt_n   = '0;
               miss_n  = '0;
            end else if (match) begin
               miss_n = '0;
            end else begin
               miss_n = miss_inc;
               if (miss_inc == UNLOCK_N) begin
                  state_n = ST_ACQUIRE;
                  lock_n  = 1'b0;
                  stab_n  = '0;
                  cnt_n   = '0;
                  miss_n  = '0;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            lock_n  = 1'b0;
            stab_n  = '0;
            cnt_n   = '0;
            miss_n  = '0;
         end
      endcase

      // Power-down wins over every other event on the edge.
      if (PWRDWN) begin
         state_n = ST_IDLE;
         prev_n  = '0;
         miss_n  = '0;
         cnt_n   = '0;
         lock_n  = 1'b0;
         stab_n  = '0;
         oor_n   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state         <= ST_IDLE;
         prev          <= '0;
         miss          <= '0;
         match_count   <= '0;
         LOCKED        <= 1'b0;
         stable_period <= '0;
         out_of_range  <= 1'b0;
      end else begin
         state         <= state_n;
         prev          <= prev_n;
         miss          <= miss_n;
         match_count   <= cnt_n;
         LOCKED        <= lock_n;
         stable_period <= stab_n;
         out_of_range  <= oor_n;
      end
   end

endmodule
